// File: rtl/step_scheduler.sv
// Tempo-driven 8-step drum scheduler: BPM accumulator ticks steps and
// serialises each step's instrument hits onto one valid/ready voice port.
module step_scheduler #(
  parameter int CLK_HZ  = 50_000_000,
  parameter int BPM_W   = 8,
  parameter int STEPS   = 8,
  parameter int NUM_INS = 4
) (
  input  logic                        clk,
  input  logic                        reset,
  input  logic                        play,
  input  logic [BPM_W-1:0]            bpm,
  input  logic [NUM_INS*STEPS-1:0]    pattern,
  output logic                        step_tick,
  output logic [$clog2(STEPS)-1:0]    step,
  output logic                        voice_valid,
  output logic [$clog2(NUM_INS)-1:0]  voice_id,
  input  logic                        voice_ready,
  output logic                        overrun
);

  localparam int SW = $clog2(STEPS);
  localparam int IW = $clog2(NUM_INS);
  localparam longint THRESH = longint'(CLK_HZ) * 30;
  localparam int ACC_W = $clog2(THRESH + (longint'(1) << BPM_W));
  localparam logic [ACC_W:0] TH = (ACC_W+1)'(THRESH);

  typedef enum logic {IDLE, RUN} state_t;

  state_t             state_q, state_d;
  logic [ACC_W-1:0]   acc_q, acc_d;
  logic [ACC_W:0]     sum;
  logic [SW-1:0]      step_q, step_d, step_n;
  logic               tick_q, tick_d;
  logic [NUM_INS-1:0] pend_q, pend_d;
  logic [NUM_INS-1:0] low, grant, left;
  logic               ovr_q, ovr_d;

  function automatic logic [NUM_INS-1:0] column(
    input logic [NUM_INS*STEPS-1:0] pat,
    input logic [SW-1:0]            s
  );
    logic [NUM_INS-1:0] c;
    for (int i = 0; i < NUM_INS; i++)
      c[i] = pat[i*STEPS + int'(s)];
    return c;
  endfunction

  // lowest set bit wins: instrument 0 has highest priority
  always_comb begin
    low      = pend_q & (~pend_q + 1'b1);
    grant    = voice_ready ? low : '0;
    left     = pend_q & ~grant;
    voice_id = '0;
    for (int i = NUM_INS-1; i >= 0; i--)
      if (pend_q[i]) voice_id = IW'(i);
  end

  assign voice_valid = |pend_q;
  assign step_tick   = tick_q;
  assign step        = step_q;
  assign overrun     = ovr_q;

  always_comb begin
    state_d = state_q;
    acc_d   = acc_q;
    step_d  = step_q;
    tick_d  = 1'b0;
    pend_d  = left;
    ovr_d   = ovr_q;
    sum     = {1'b0, acc_q} + (ACC_W+1)'(bpm);
    step_n  = step_q + 1'b1;
    unique case (state_q)
      IDLE: begin
        acc_d  = '0;
        step_d = '0;
        pend_d = '0;
        if (play) begin
          state_d = RUN;
          tick_d  = 1'b1;
          pend_d  = column(pattern, '0);
          ovr_d   = 1'b0;
        end
      end
      RUN: begin
        if (!play) begin
          state_d = IDLE;
          acc_d   = '0;
          step_d  = '0;
          pend_d  = '0;
        end else if (sum >= TH) begin
          acc_d  = ACC_W'(sum - TH);
          tick_d = 1'b1;
          step_d = step_n;
          pend_d = column(pattern, step_n);
          if (|left) ovr_d = 1'b1;
        end else begin
          acc_d = sum[ACC_W-1:0];
        end
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (!reset) begin
      state_q <= IDLE;
      acc_q   <= '0;
      step_q  <= '0;
      tick_q  <= 1'b0;
      pend_q  <= '0;
      ovr_q   <= 1'b0;
    end else begin
      state_q <= state_d;
      acc_q   <= acc_d;
      step_q  <= step_d;
      tick_q  <= tick_d;
      pend_q  <= pend_d;
      ovr_q   <= ovr_d;
    end
  end

endmodule

// File: tb/tb_step_scheduler.sv
// Bench for step_scheduler: vector table, directed corner sequences and
// random traffic against a cycle-level queue/arithmetic reference model.
module tb_step_scheduler;

  localparam int CLK_HZ  = 100;
  localparam int STEPS   = 8;
  localparam int NUM_INS = 4;
  localparam longint THRESH = longint'(CLK_HZ) * 30;

  logic        clk = 1'b0;
  logic        reset = 1'b0;
  logic        play = 1'b0;
  logic [7:0]  bpm = 8'd0;
  logic [31:0] pattern = '0;
  logic        voice_ready = 1'b0;
  logic        step_tick;
  logic [2:0]  step;
  logic        voice_valid;
  logic [1:0]  voice_id;
  logic        overrun;

  step_scheduler #(
    .CLK_HZ(CLK_HZ), .BPM_W(8), .STEPS(STEPS), .NUM_INS(NUM_INS)
  ) dut (
    .clk(clk), .reset(reset), .play(play), .bpm(bpm),
    .pattern(pattern), .step_tick(step_tick), .step(step),
    .voice_valid(voice_valid), .voice_id(voice_id),
    .voice_ready(voice_ready), .overrun(overrun)
  );

  always #5 clk = ~clk;

  int errors = 0;
  int checks = 0;

  task automatic chk(input string name, input logic [63:0] act,
                     input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
    end
  endtask

  // reference model: total bpm accumulated since entry, tick on each
  // crossing of a THRESH multiple; pending hits held as an id queue
  bit     m_run;
  longint m_total;
  int     m_step;
  bit     m_tick;
  bit     m_ovr;
  int     m_q[$];

  task automatic load_col(input int s);
    m_q.delete();
    for (int i = 0; i < NUM_INS; i++)
      if (pattern[i*STEPS + s]) m_q.push_back(i);
  endtask

  task automatic model_update();
    longint nt;
    if (!reset) begin
      m_run = 0; m_total = 0; m_step = 0; m_tick = 0; m_ovr = 0;
      m_q.delete();
    end else if (!m_run) begin
      m_tick = 0;
      if (play) begin
        m_run = 1; m_total = 0; m_step = 0; m_tick = 1; m_ovr = 0;
        load_col(0);
      end
    end else if (!play) begin
      m_run = 0; m_total = 0; m_step = 0; m_tick = 0;
      m_q.delete();
    end else begin
      if (voice_ready && m_q.size() > 0) void'(m_q.pop_front());
      nt = m_total + longint'(bpm);
      m_tick = (nt / THRESH) != (m_total / THRESH);
      m_total = nt;
      if (m_tick) begin
        m_step = (m_step + 1) % STEPS;
        if (m_q.size() != 0) m_ovr = 1;
        load_col(m_step);
      end
    end
  endtask

  task automatic cyc();
    @(posedge clk);
    model_update();
    @(negedge clk);
    chk("m_tick", step_tick, m_tick);
    chk("m_step", step, m_step);
    chk("m_valid", voice_valid, m_q.size() > 0);
    if (m_q.size() > 0) chk("m_id", voice_id, m_q[0]);
    chk("m_ovr", overrun, m_ovr);
  endtask

  int ticks;
  task automatic go(input int n);
    for (int i = 0; i < n; i++) begin
      cyc();
      if (step_tick) ticks++;
    end
  endtask

  typedef struct {
    logic rst; logic ply; logic [7:0] b; logic [31:0] pat; logic rdy;
    logic tk; logic [2:0] st; logic vv; logic [1:0] id; logic ov;
  } vec_t;
  vec_t tv[6];

  initial begin
    int   last, bad, nids;
    int   ids[$];
    logic [31:0] pat3;
    pat3 = 32'h0201_0001;
    tv[0] = '{1'b0, 1'b1, 8'd120, pat3, 1'b1, 1'b0, 3'd0, 1'b0, 2'd0, 1'b0};
    tv[1] = '{1'b0, 1'b1, 8'd120, pat3, 1'b1, 1'b0, 3'd0, 1'b0, 2'd0, 1'b0};
    tv[2] = '{1'b0, 1'b1, 8'd120, pat3, 1'b1, 1'b0, 3'd0, 1'b0, 2'd0, 1'b0};
    tv[3] = '{1'b1, 1'b1, 8'd120, pat3, 1'b1, 1'b1, 3'd0, 1'b1, 2'd0, 1'b0};
    tv[4] = '{1'b1, 1'b1, 8'd120, pat3, 1'b1, 1'b0, 3'd0, 1'b1, 2'd2, 1'b0};
    tv[5] = '{1'b1, 1'b1, 8'd120, pat3, 1'b1, 1'b0, 3'd0, 1'b0, 2'd0, 1'b0};

    @(negedge clk);
    for (int i = 0; i < 6; i++) begin
      reset = tv[i].rst; play = tv[i].ply; bpm = tv[i].b;
      pattern = tv[i].pat; voice_ready = tv[i].rdy;
      cyc();
      chk($sformatf("v%0d_tick", i), step_tick, tv[i].tk);
      chk($sformatf("v%0d_step", i), step, tv[i].st);
      chk($sformatf("v%0d_valid", i), voice_valid, tv[i].vv);
      if (tv[i].vv) chk($sformatf("v%0d_id", i), voice_id, tv[i].id);
      chk($sformatf("v%0d_ovr", i), overrun, tv[i].ov);
    end

    // empty pattern: 25-cycle period, 8 steps wrap, no triggers
    play = 0; pattern = '0; cyc();
    play = 1; cyc();
    chk("t2_entry", {step_tick, step}, {1'b1, 3'd0});
    last = 0; bad = 0; ticks = 0; nids = 0;
    for (int c = 1; c <= 200; c++) begin
      cyc();
      if (voice_valid) nids++;
      if (step_tick) begin
        ticks++;
        if (c - last != 25) bad++;
        if (step != 3'(ticks)) bad++;
        last = c;
      end
    end
    chk("t2_ticks", ticks, 8);
    chk("t2_period", bad, 0);
    chk("t2_wrap", step, 0);
    chk("t2_novoice", nids, 0);

    // ins0+ins2 on step0, ins3 on step1
    play = 0; cyc();
    pattern = pat3; play = 1;
    for (int c = 0; c < 27; c++) begin
      cyc();
      if (voice_valid && voice_ready) ids.push_back(int'(voice_id));
    end
    chk("t3_n", ids.size(), 3);
    if (ids.size() == 3) begin
      chk("t3_id0", ids[0], 0);
      chk("t3_id1", ids[1], 2);
      chk("t3_id2", ids[2], 3);
    end
    chk("t3_ovr", overrun, 0);

    // all hit step0, never accepted before tick 1
    play = 0; cyc();
    pattern = 32'h0101_0101; voice_ready = 0; play = 1; cyc();
    go(24);
    chk("t4_pre_ovr", overrun, 0);
    chk("t4_pre_valid", voice_valid, 1);
    go(1);
    chk("t4_tick", {step_tick, step}, {1'b1, 3'd1});
    chk("t4_ovr", overrun, 1);
    chk("t4_valid", voice_valid, 0);
    voice_ready = 1; go(3);

    // bpm=0 freezes the tempo
    play = 0; cyc();
    pattern = $urandom; play = 1; cyc();
    bpm = 0; ticks = 0; go(1000);
    chk("t5_noticks", ticks, 0);
    chk("t5_step", step, 0);
    bpm = 120; ticks = 0; go(30);
    chk("t5_resume", ticks, 1);

    // abort mid-dispatch by play, then by reset
    play = 0; cyc();
    pattern = 32'h0001_0300; voice_ready = 0; play = 1; cyc();
    chk("t6_id", {voice_valid, voice_id}, {1'b1, 2'd1});
    go(25);
    chk("t6_ovr", overrun, 1);
    play = 0; cyc();
    chk("t6_stop", {voice_valid, step}, {1'b0, 3'd0});
    play = 1; cyc();
    chk("t6_reentry", {step_tick, step, overrun}, {1'b1, 3'd0, 1'b0});
    go(25);
    chk("t6_ovr2", overrun, 1);
    reset = 0; cyc();
    chk("t6_rst", {step_tick, voice_valid, step, overrun}, 6'd0);
    reset = 1; cyc();
    chk("t6_rst_entry", {step_tick, step}, {1'b1, 3'd0});

    // random traffic against the model
    for (int c = 0; c < 4000; c++) begin
      if ($urandom_range(99) < 3) bpm = 8'($urandom_range(255, 60));
      if ($urandom_range(199) == 0) bpm = 0;
      if ($urandom_range(49) == 0) pattern = $urandom;
      voice_ready = $urandom_range(3) != 0;
      play = $urandom_range(199) != 0;
      reset = $urandom_range(399) != 0;
      cyc();
    end

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
